dsram_resp: RTL

DSRAM_RESP -- requirements
Module: dsram_resp

---
 rtl/dsram_resp_pkg.sv | 23 ++
 rtl/dsram_resp_sram_byte_ram.sv | 30 +++
 rtl/dsram_resp.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dsram_resp_pkg.sv
// Shared constants and types for the dsram_resp data-side responder.
//   MMIO_HI_DEF : default addr[31:16] value selecting the MMIO window
//   *_OFF       : addr[15:0] offsets of the MMIO registers
//   RAM_AW_DEF  : default word-address width of the internal RAM
//   rd_src_e    : which source drives data_sram_rdata after a read
package dsram_resp_pkg;

  localparam int unsigned RAM_AW_DEF  = 10;
  localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;

  localparam logic [15:0] LED_OFF    = 16'hF000;
  localparam logic [15:0] SWITCH_OFF = 16'hF004;
  localparam logic [15:0] TIMER_OFF  = 16'hE000;

  // SRC_NONE is the post-reset state: the output reads as zero until the
  // first read completes.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_MMIO = 2'd2
  } rd_src_e;

endpackage

// File: rtl/dsram_resp_sram_byte_ram.sv
// sram_byte_ram: synchronous single-port RAM, 32-bit words, 4 byte lanes.
//   clk   : clock
//   en    : access enable; en with wen==0 is a read
//   wen   : byte-lane write enables
//   addr  : word address
//   wdata : write data, lane n = bits [8n+7:8n]
//   rdata : registered read data; updates only on reads, no reset
module sram_byte_ram #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (wen == 4'h0) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dsram_resp.sv
// dsram_resp: data-side SRAM responder with an internal RAM and a small MMIO
// window (LED register, synchronised switches, free-running timer).
//   clk             : clock
//   rst             : asynchronous active-high reset
//   data_sram_en    : access request this cycle
//   data_sram_wen   : byte-lane write enables (0 = read)
//   data_sram_addr  : byte address, bits [1:0] ignored
//   data_sram_wdata : write data
//   data_sram_rdata : read data, one cycle after the read request
//   led             : LED register
//   switch          : asynchronous switch inputs
module dsram_resp
  import dsram_resp_pkg::*;
#(
  parameter int unsigned RAM_AW  = RAM_AW_DEF,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  input  logic [7:0]  switch
);

  localparam logic [13:0] LED_WORD    = LED_OFF[15:2];
  localparam logic [13:0] SWITCH_WORD = SWITCH_OFF[15:2];
  localparam logic [13:0] TIMER_WORD  = TIMER_OFF[15:2];

  logic        is_mmio;
  logic [13:0] mmio_word;
  logic        rd_req;
  logic        wr_req;
  logic        ram_en;
  logic        led_wr;
  logic        timer_wr;
  logic [31:0] mmio_rd_data;
  logic [31:0] ram_rdata_p1;
  logic [31:0] mmio_rdata_p1;
  rd_src_e     src_p1;
  logic [15:0] led_q;
  logic [31:0] timer;
  logic [7:0]  sw_sync_p0;
  logic [7:0]  sw_sync_p1;
  logic [1:0]  unused_addr_lsb;

  assign unused_addr_lsb = data_sram_addr[1:0];

  // Request decode (request cycle)
  assign is_mmio   = (data_sram_addr[31:16] == MMIO_HI);
  assign mmio_word = data_sram_addr[15:2];
  assign rd_req    = data_sram_en && (data_sram_wen == 4'h0);
  assign wr_req    = data_sram_en && (data_sram_wen != 4'h0);
  assign ram_en    = data_sram_en && !is_mmio;
  assign led_wr    = wr_req && is_mmio && (mmio_word == LED_WORD);
  // Only a full-word write may load the timer; partial writes are dropped.
  assign timer_wr  = wr_req && is_mmio && (mmio_word == TIMER_WORD) &&
                     (data_sram_wen == 4'hF);

  sram_byte_ram #(
    .AW (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .wen   (data_sram_wen),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rdata_p1)
  );

  always_comb begin
    mmio_rd_data = 32'h0;
    case (mmio_word)
      LED_WORD:    mmio_rd_data = {16'h0, led_q};
      SWITCH_WORD: mmio_rd_data = {24'h0, sw_sync_p1};
      TIMER_WORD:  mmio_rd_data = timer;
      default:     mmio_rd_data = 32'h0;
    endcase
  end

  // Request -> response boundary: source select and MMIO read data are
  // captured on the same edge as the RAM's own read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_p1 <= SRC_NONE;
    end else if (rd_req) begin
      src_p1 <= is_mmio ? SRC_MMIO : SRC_RAM;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_req && is_mmio) mmio_rdata_p1 <= mmio_rd_data;
  end

  always_comb begin
    data_sram_rdata = 32'h0;
    case (src_p1)
      SRC_RAM:  data_sram_rdata = ram_rdata_p1;
      SRC_MMIO: data_sram_rdata = mmio_rdata_p1;
      default:  data_sram_rdata = 32'h0;
    endcase
  end

  // MMIO state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q      <= 16'h0;
      timer      <= 32'h0;
      sw_sync_p0 <= 8'h0;
      sw_sync_p1 <= 8'h0;
    end else begin
      if (led_wr) begin
        if (data_sram_wen[0]) led_q[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_wen[1]) led_q[15:8] <= data_sram_wdata[15:8];
      end
      timer      <= timer_wr ? data_sram_wdata : timer + 32'd1;
      sw_sync_p0 <= switch;
      sw_sync_p1 <= sw_sync_p0;
    end
  end

  assign led = led_q;

endmodule
